// File: rtl/rom_instr_sequencer_if.sv
// Opcode bus between the instruction sequencer (master) and the RAM/ALU
// block (slave).
//   opcode       : opcode word, 0 while no instruction is executing
//   operand      : operand word, 0 while no instruction is executing
//   write_data   : copy of operand while executing, else 0
//   read_enable  : one-cycle strobe for read-class instructions
//   write_enable : one-cycle strobe for write-class instructions
//   read_data    : slave return data, combinational while read_enable is high
interface rom_instr_sequencer_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] opcode;
    logic [DATA_WIDTH-1:0] operand;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  read_enable;
    logic                  write_enable;
    logic [DATA_WIDTH-1:0] read_data;

    modport master (
        output opcode, operand, write_data, read_enable, write_enable,
        input  read_data
    );

    modport slave (
        input  opcode, operand, write_data, read_enable, write_enable,
        output read_data
    );
endinterface

// File: rtl/rom_instr_sequencer.sv
// rom_instr_sequencer: fetch/issue stage in front of the RAM block.
// Each instruction is two ROM words (opcode, operand), fetched in a fixed
// four-cycle loop FETCH0 -> FETCH1 -> FETCH2 -> EXEC. In EXEC the words are
// presented on the opcode bus with a one-cycle read or write strobe; HALT
// (opcode[15:8]==0x00) and JUMP (opcode[15:12]==0xF) are handled locally.
//
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   start        : run from pc 0 (accepted in IDLE/HALTED, and PAUSED)
//   step         : (SEQ_SINGLE_STEP_EN only) resume from PAUSED
//   rom_addr     : ROM word address; rom_data returns one cycle later
//   rom_data     : ROM read data
//   bus          : opcode bus master (opcode/operand/write_data/strobes/read_data)
//   result       : last read_data captured by a read-class instruction
//   result_valid : one-cycle pulse the cycle after a capture
//   pc           : address of the current instruction
//   busy         : high in FETCH0..EXEC
//   halted       : high in HALTED
//   retired      : executed-instruction count, wraps at 16 bits
//
// Optional build macro SEQ_SINGLE_STEP_EN adds the step input and a PAUSED
// state entered after every non-HALT instruction.
module rom_instr_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_W     = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic                  step,
`endif
    output logic [ADDR_W-1:0]     rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    rom_instr_sequencer_if.master bus,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  result_valid,
    output logic [ADDR_W-1:0]     pc,
    output logic                  busy,
    output logic                  halted,
    output logic [15:0]           retired
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH0, S_FETCH1, S_FETCH2, S_EXEC, S_HALTED
`ifdef SEQ_SINGLE_STEP_EN
        , S_PAUSED
`endif
    } state_t;

    state_t                r_state;
    logic [ADDR_W-1:0]     r_pc;
    logic [ADDR_W-1:0]     r_rom_addr;
    logic [DATA_WIDTH-1:0] r_opcode_q;
    logic [DATA_WIDTH-1:0] r_opcode;
    logic [DATA_WIDTH-1:0] r_operand;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_wr_en;
    logic                  r_rd_en;
    logic [DATA_WIDTH-1:0] r_result;
    logic                  r_result_valid;
    logic [15:0]           r_retired;

    logic [ADDR_W-1:0]     w_pc_seq;
    logic [ADDR_W-1:0]     w_pc_next;

    function automatic logic f_is_write(input logic [7:0] hi);
        return (hi == 8'h31) || (hi == 8'h41) || (hi == 8'h11);
    endfunction

    function automatic logic f_is_read(input logic [7:0] hi);
        return (hi == 8'h42) || (hi == 8'h12);
    endfunction

    function automatic logic f_is_halt(input logic [7:0] hi);
        return hi == 8'h00;
    endfunction

    function automatic logic f_is_jump(input logic [7:0] hi);
        return hi[7:4] == 4'hF;
    endfunction

    // Sequential advance wraps naturally at 2^ADDR_W.
    assign w_pc_seq  = r_pc + ADDR_W'(2);
    // r_operand holds operand_q throughout EXEC, which is when this is used.
    assign w_pc_next = f_is_jump(r_opcode_q[15:8]) ? r_operand[ADDR_W-1:0] : w_pc_seq;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_pc           <= '0;
            r_rom_addr     <= '0;
            r_opcode_q     <= '0;
            r_opcode       <= '0;
            r_operand      <= '0;
            r_wdata        <= '0;
            r_wr_en        <= 1'b0;
            r_rd_en        <= 1'b0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_retired      <= '0;
        end else begin
            r_result_valid <= 1'b0;
            case (r_state)
                S_IDLE, S_HALTED: begin
                    if (start) begin
                        r_pc       <= '0;
                        r_rom_addr <= '0;
                        r_state    <= S_FETCH0;
                    end
                end
`ifdef SEQ_SINGLE_STEP_EN
                S_PAUSED: begin
                    if (start) begin
                        r_pc       <= '0;
                        r_rom_addr <= '0;
                        r_state    <= S_FETCH0;
                    end else if (step) begin
                        // rom_addr already points at the updated pc
                        r_state <= S_FETCH0;
                    end
                end
`endif
                S_FETCH0: begin
                    r_rom_addr <= r_pc + 1'b1;
                    r_state    <= S_FETCH1;
                end
                S_FETCH1: begin
                    r_opcode_q <= rom_data;
                    r_state    <= S_FETCH2;
                end
                S_FETCH2: begin
                    // Load bus outputs and strobes so they are registered in EXEC.
                    r_opcode  <= r_opcode_q;
                    r_operand <= rom_data;
                    r_wdata   <= rom_data;
                    r_wr_en   <= f_is_write(r_opcode_q[15:8]);
                    r_rd_en   <= f_is_read(r_opcode_q[15:8]);
                    r_state   <= S_EXEC;
                end
                S_EXEC: begin
                    r_opcode  <= '0;
                    r_operand <= '0;
                    r_wdata   <= '0;
                    r_wr_en   <= 1'b0;
                    r_rd_en   <= 1'b0;
                    r_retired <= r_retired + 16'd1;
                    if (r_rd_en) begin
                        r_result       <= bus.read_data;
                        r_result_valid <= 1'b1;
                    end
                    if (f_is_halt(r_opcode_q[15:8])) begin
                        r_state <= S_HALTED;
                    end else begin
                        r_pc       <= w_pc_next;
                        r_rom_addr <= w_pc_next;
`ifdef SEQ_SINGLE_STEP_EN
                        r_state    <= S_PAUSED;
`else
                        r_state    <= S_FETCH0;
`endif
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rom_addr         = r_rom_addr;
    assign pc               = r_pc;
    assign result           = r_result;
    assign result_valid     = r_result_valid;
    assign retired          = r_retired;
    assign busy             = (r_state == S_FETCH0) || (r_state == S_FETCH1) ||
                              (r_state == S_FETCH2) || (r_state == S_EXEC);
    assign halted           = (r_state == S_HALTED);

    assign bus.opcode       = r_opcode;
    assign bus.operand      = r_operand;
    assign bus.write_data   = r_wdata;
    // Strobes are masked while reset is held so an aborted instruction never issues.
    assign bus.write_enable = r_wr_en & ~reset;
    assign bus.read_enable  = r_rd_en & ~reset;

endmodule

// File: tb/tb_rom_instr_sequencer.sv
module tb_rom_instr_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_a = 1'b0;
    logic        start_b = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
    logic        step_a = 1'b0;
`endif

    logic [7:0]  rom_addr_a;
    logic [15:0] rom_data_a;
    logic [15:0] result_a;
    logic        rv_a;
    logic [7:0]  pc_a;
    logic        busy_a, halted_a;
    logic [15:0] retired_a;

    logic [1:0]  rom_addr_b;
    logic [15:0] rom_data_b;
    logic [15:0] result_b;
    logic        rv_b;
    logic [1:0]  pc_b;
    logic        busy_b, halted_b;
    logic [15:0] retired_b;

    logic [15:0] rom_a [256];
    logic [15:0] rom_b [4];
    logic [15:0] ram_a [256];

    int n_chk = 0;
    int n_err = 0;

    // pulse bookkeeping updated by tick()
    int          n_we, n_re, n_rv;
    logic [15:0] re_op, rv_val;
    logic        prev_re, rv_ok, saw_wrap;
    logic [1:0]  prev_addr_b;

    rom_instr_sequencer_if #(.DATA_WIDTH(16)) bus_a ();
    rom_instr_sequencer_if #(.DATA_WIDTH(16)) bus_b ();

    always #5 clk = ~clk;

    rom_instr_sequencer #(.DATA_WIDTH(16), .ADDR_W(8)) dut_a (
        .clk          (clk),
        .reset        (reset),
        .start        (start_a),
`ifdef SEQ_SINGLE_STEP_EN
        .step         (step_a),
`endif
        .rom_addr     (rom_addr_a),
        .rom_data     (rom_data_a),
        .bus          (bus_a),
        .result       (result_a),
        .result_valid (rv_a),
        .pc           (pc_a),
        .busy         (busy_a),
        .halted       (halted_a),
        .retired      (retired_a)
    );

    rom_instr_sequencer #(.DATA_WIDTH(16), .ADDR_W(2)) dut_b (
        .clk          (clk),
        .reset        (reset),
        .start        (start_b),
`ifdef SEQ_SINGLE_STEP_EN
        .step         (1'b0),
`endif
        .rom_addr     (rom_addr_b),
        .rom_data     (rom_data_b),
        .bus          (bus_b),
        .result       (result_b),
        .result_valid (rv_b),
        .pc           (pc_b),
        .busy         (busy_b),
        .halted       (halted_b),
        .retired      (retired_b)
    );

    // Synchronous ROMs: data valid the cycle after the address.
    always @(posedge clk) rom_data_a <= rom_a[rom_addr_a];
    always @(posedge clk) rom_data_b <= rom_b[rom_addr_b];

    // RAM model addressed by opcode[7:0]; data comes from write_data.
    always @(posedge clk) if (bus_a.write_enable) ram_a[bus_a.opcode[7:0]] <= bus_a.write_data;
    assign bus_a.read_data = bus_a.read_enable ? ram_a[bus_a.opcode[7:0]] : 16'h0000;
    assign bus_b.read_data = 16'h0000;

    typedef struct {
        logic        start;
        logic        busy;
        logic        halted;
        logic [7:0]  pc;
        logic        ca;
        logic [7:0]  addr;
        logic [15:0] op;
        logic [15:0] opnd;
        logic [15:0] wd;
        logic        we;
        logic        re;
        logic [15:0] ret;
    } vec_t;

    vec_t t1 [11];

    function automatic vec_t mk(input logic s, input logic b, input logic h,
                                input logic [7:0] p, input logic ca, input logic [7:0] a,
                                input logic [15:0] op, input logic [15:0] opnd,
                                input logic [15:0] wd, input logic we, input logic re,
                                input logic [15:0] ret);
        vec_t v;
        v.start = s; v.busy = b; v.halted = h; v.pc = p; v.ca = ca; v.addr = a;
        v.op = op; v.opnd = opnd; v.wd = wd; v.we = we; v.re = re; v.ret = ret;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic clr_counts();
        n_we = 0; n_re = 0; n_rv = 0;
        re_op = '0; rv_val = '0;
        prev_re = 1'b0; rv_ok = 1'b0; saw_wrap = 1'b0;
        prev_addr_b = rom_addr_b;
    endtask

    // One clock; outputs sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        if (bus_a.write_enable) n_we++;
        if (bus_a.read_enable) begin
            n_re++;
            re_op = bus_a.opcode;
        end
        if (rv_a) begin
            n_rv++;
            rv_val = result_a;
            rv_ok  = prev_re;
        end
        prev_re = bus_a.read_enable;
        if (prev_addr_b == 2'd3 && rom_addr_b == 2'd0) saw_wrap = 1'b1;
        prev_addr_b = rom_addr_b;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic clear_rom_a();
        for (int i = 0; i < 256; i++) rom_a[i] = 16'h0000;
    endtask

    task automatic wait_halt_a(input string nm, input int budget);
        int k;
        k = 0;
        while (!halted_a && k < budget) begin
            tick();
            k++;
        end
        chk({nm, ".halted"}, {31'd0, halted_a}, 32'd1);
    endtask

    task automatic check_reset_state(input string nm);
        chk({nm, ".busy"},    {31'd0, busy_a},    32'd0);
        chk({nm, ".halted"},  {31'd0, halted_a},  32'd0);
        chk({nm, ".pc"},      {24'd0, pc_a},      32'd0);
        chk({nm, ".addr"},    {24'd0, rom_addr_a}, 32'd0);
        chk({nm, ".opcode"},  {16'd0, bus_a.opcode},     32'd0);
        chk({nm, ".wdata"},   {16'd0, bus_a.write_data}, 32'd0);
        chk({nm, ".we"},      {31'd0, bus_a.write_enable}, 32'd0);
        chk({nm, ".re"},      {31'd0, bus_a.read_enable},  32'd0);
        chk({nm, ".result"},  {16'd0, result_a},  32'd0);
        chk({nm, ".rv"},      {31'd0, rv_a},      32'd0);
        chk({nm, ".retired"}, {16'd0, retired_a}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        clear_rom_a();
        for (int i = 0; i < 4; i++) rom_b[i] = 16'h0000;

        // ---- reset state ----
        @(negedge clk);
        clr_counts();
        do_reset();
        check_reset_state("rst");
        chk("rst.b_pc", {30'd0, pc_b}, 32'd0);

        // ---- write then HALT, cycle by cycle ----
        rom_a[0] = 16'h3105; rom_a[1] = 16'hBEEF; rom_a[2] = 16'h0000; rom_a[3] = 16'h0000;
        //            st b  h  pc    ca addr   op        opnd      wd       we re ret
        t1[0]  = mk(1, 1, 0, 8'd0, 1, 8'd0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'd0);
        t1[1]  = mk(0, 1, 0, 8'd0, 1, 8'd1, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'd0);
        t1[2]  = mk(0, 1, 0, 8'd0, 1, 8'd1, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'd0);
        t1[3]  = mk(0, 1, 0, 8'd0, 1, 8'd1, 16'h3105, 16'hBEEF, 16'hBEEF, 1, 0, 16'd0);
        t1[4]  = mk(0, 1, 0, 8'd2, 1, 8'd2, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'd1);
        t1[5]  = mk(0, 1, 0, 8'd2, 1, 8'd3, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'd1);
        t1[6]  = mk(0, 1, 0, 8'd2, 1, 8'd3, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'd1);
        t1[7]  = mk(0, 1, 0, 8'd2, 1, 8'd3, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'd1);
        t1[8]  = mk(0, 0, 1, 8'd2, 0, 8'd0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'd2);
        t1[9]  = mk(0, 0, 1, 8'd2, 0, 8'd0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'd2);
        t1[10] = mk(1, 1, 0, 8'd0, 1, 8'd0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'd2);
        for (int i = 0; i < 11; i++) begin
            start_a = t1[i].start;
            tick();
            chk($sformatf("t1[%0d].busy", i),    {31'd0, busy_a},   {31'd0, t1[i].busy});
            chk($sformatf("t1[%0d].halted", i),  {31'd0, halted_a}, {31'd0, t1[i].halted});
            chk($sformatf("t1[%0d].pc", i),      {24'd0, pc_a},     {24'd0, t1[i].pc});
            if (t1[i].ca)
                chk($sformatf("t1[%0d].addr", i), {24'd0, rom_addr_a}, {24'd0, t1[i].addr});
            chk($sformatf("t1[%0d].opcode", i),  {16'd0, bus_a.opcode},     {16'd0, t1[i].op});
            chk($sformatf("t1[%0d].operand", i), {16'd0, bus_a.operand},    {16'd0, t1[i].opnd});
            chk($sformatf("t1[%0d].wdata", i),   {16'd0, bus_a.write_data}, {16'd0, t1[i].wd});
            chk($sformatf("t1[%0d].we", i),      {31'd0, bus_a.write_enable}, {31'd0, t1[i].we});
            chk($sformatf("t1[%0d].re", i),      {31'd0, bus_a.read_enable},  {31'd0, t1[i].re});
            chk($sformatf("t1[%0d].retired", i), {16'd0, retired_a}, {16'd0, t1[i].ret});
        end
        start_a = 1'b0;

        // ---- write then read back through the RAM model ----
        clear_rom_a();
        rom_a[0] = 16'h4105; rom_a[1] = 16'h1234;
        rom_a[2] = 16'h4205; rom_a[3] = 16'h0005;
        do_reset();
        clr_counts();
        start_a = 1'b1; tick(); start_a = 1'b0;
        wait_halt_a("rd", 40);
        chk("rd.n_we",    n_we, 32'd1);
        chk("rd.n_re",    n_re, 32'd1);
        chk("rd.re_op",   {16'd0, re_op}, 32'h4205);
        chk("rd.n_rv",    n_rv, 32'd1);
        chk("rd.rv_val",  {16'd0, rv_val}, 32'h1234);
        chk("rd.rv_next", {31'd0, rv_ok}, 32'd1);
        chk("rd.result",  {16'd0, result_a}, 32'h1234);
        chk("rd.pc",      {24'd0, pc_a}, 32'd4);
        chk("rd.retired", {16'd0, retired_a}, 32'd3);

        // ---- JUMP ----
        clear_rom_a();
        rom_a[0] = 16'hF000; rom_a[1] = 16'h0006; rom_a[6] = 16'h0000;
        do_reset();
        clr_counts();
        start_a = 1'b1; tick(); start_a = 1'b0;
        k = 0;
        while (!bus_a.opcode[15] && k < 10) begin tick(); k++; end
        tick();
        chk("jmp.pc_after", {24'd0, pc_a}, 32'd6);
        wait_halt_a("jmp", 20);
        chk("jmp.n_we",    n_we, 32'd0);
        chk("jmp.n_re",    n_re, 32'd0);
        chk("jmp.pc",      {24'd0, pc_a}, 32'd6);
        chk("jmp.retired", {16'd0, retired_a}, 32'd2);

        // ---- PC wrap with ADDR_W=2 ----
        rom_b[0] = 16'hF000; rom_b[1] = 16'h0003; rom_b[2] = 16'h0000; rom_b[3] = 16'h0000;
        do_reset();
        clr_counts();
        start_b = 1'b1; tick(); start_b = 1'b0;
        k = 0;
        while (!halted_b && k < 20) begin tick(); k++; end
        chk("wrap.halted",  {31'd0, halted_b}, 32'd1);
        chk("wrap.pc",      {30'd0, pc_b}, 32'd3);
        chk("wrap.3then0",  {31'd0, saw_wrap}, 32'd1);
        chk("wrap.retired", {16'd0, retired_b}, 32'd2);

        // ---- reset during FETCH2 of a write ----
        clear_rom_a();
        rom_a[0] = 16'h3105; rom_a[1] = 16'hBEEF;
        do_reset();
        clr_counts();
        start_a = 1'b1; tick(); start_a = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        check_reset_state("abort");
        reset = 1'b0;
        tick();
        chk("abort.idle_busy", {31'd0, busy_a}, 32'd0);
        chk("abort.n_we",      n_we, 32'd0);
        start_a = 1'b1; tick(); start_a = 1'b0;
        chk("abort.restart_pc",   {24'd0, pc_a}, 32'd0);
        chk("abort.restart_busy", {31'd0, busy_a}, 32'd1);
        wait_halt_a("abort", 20);
        chk("abort.n_we_after", n_we, 32'd1);
        chk("abort.pc",         {24'd0, pc_a}, 32'd2);
        chk("abort.retired",    {16'd0, retired_a}, 32'd2);

`ifdef SEQ_SINGLE_STEP_EN
        // ---- single step ----
        clear_rom_a();
        rom_a[0] = 16'h3101; rom_a[1] = 16'hAAAA;
        rom_a[2] = 16'h3102; rom_a[3] = 16'hBBBB;
        do_reset();
        clr_counts();
        start_a = 1'b1; tick(); start_a = 1'b0;
        k = 0;
        while (n_we < 1 && k < 10) begin tick(); k++; end
        tick();
        chk("step.paused_busy",   {31'd0, busy_a}, 32'd0);
        chk("step.paused_halted", {31'd0, halted_a}, 32'd0);
        chk("step.paused_pc",     {24'd0, pc_a}, 32'd2);
        tick(); tick(); tick();
        chk("step.hold_n_we", n_we, 32'd1);
        step_a = 1'b1; tick(); step_a = 1'b0;
        k = 1;
        while (n_we < 2 && k < 10) begin tick(); k++; end
        chk("step.latency", k, 32'd4);
        tick();
        chk("step.paused2_busy", {31'd0, busy_a}, 32'd0);
        step_a = 1'b1; tick(); step_a = 1'b0;
        wait_halt_a("step", 20);
        chk("step.retired", {16'd0, retired_a}, 32'd3);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
